// File: rtl/bpsk_demapper.sv
// BPSK demapper: slices the real part of data subcarriers into packed 32-bit words,
// with frame-length checking and a small output word FIFO.
module bpsk_demapper #(
  parameter int unsigned FFT_SIZE  = 1024,
  parameter int unsigned LO_LAST   = 400,
  parameter int unsigned HI_FIRST  = 623,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_mod,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err,
  output logic [15:0] err_count
);

  localparam int unsigned SUBC_W   = $clog2(FFT_SIZE);
  localparam int unsigned NUM_DATA = LO_LAST + (FFT_SIZE - 1 - HI_FIRST);
  localparam int unsigned WORDS    = NUM_DATA / 32;
  localparam int unsigned WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(OUT_DEPTH + 1);
  localparam int unsigned ENTRY_W  = 33;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_RESYNC = 1'b1;

  // Frame tracking state
  logic [0:0]        r_state;
  logic [SUBC_W-1:0] r_subc;
  logic [4:0]        r_bitc;
  logic [WORD_W-1:0] r_wordc;
  logic [31:0]       r_shift;
  logic              r_frame_err;
  logic [15:0]       r_err_cnt;

  // Output FIFO state
  logic [ENTRY_W-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_count;

  logic              w_clr;
  logic              w_accept;
  logic              w_pop;
  logic              w_bit;
  logic              w_is_data;
  logic              w_is_last_subc;
  logic [0:0]        w_state_nxt;
  logic [SUBC_W-1:0] w_subc_nxt;
  logic [4:0]        w_bitc_nxt;
  logic [WORD_W-1:0] w_wordc_nxt;
  logic [31:0]       w_shift_nxt;
  logic              w_push;
  logic [31:0]       w_push_word;
  logic              w_push_last;
  logic              w_err;
  logic [ENTRY_W-1:0] w_head;
  logic              w_unused_bits;

  assign w_unused_bits  = ^{s_axis_tdata[31:16], s_axis_tdata[14:0]};

  assign w_clr          = ~rst | reset_mod;
  assign s_axis_tready  = ~w_clr & (r_count < CNT_W'(OUT_DEPTH));
  assign w_accept       = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid  = (r_count != '0);
  assign w_pop          = m_axis_tvalid & m_axis_tready;
  assign w_bit          = ~s_axis_tdata[15];
  assign w_is_last_subc = (r_subc == SUBC_W'(FFT_SIZE - 1));
  assign w_is_data      = ((r_subc >= SUBC_W'(1))        && (r_subc <= SUBC_W'(LO_LAST))) ||
                          ((r_subc >= SUBC_W'(HI_FIRST)) && (r_subc <= SUBC_W'(FFT_SIZE - 2)));

  assign w_head         = r_mem[r_rd];
  assign m_axis_tdata   = m_axis_tvalid ? w_head[31:0] : 32'd0;
  assign m_axis_tlast   = m_axis_tvalid & w_head[32];
  assign frame_err      = r_frame_err;
  assign err_count      = r_err_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state, counter and word-assembly logic
  always_comb begin
    w_state_nxt = r_state;
    w_subc_nxt  = r_subc;
    w_bitc_nxt  = r_bitc;
    w_wordc_nxt = r_wordc;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_push_word = '0;
    w_push_last = 1'b0;
    w_err       = 1'b0;

    if (w_accept) begin
      unique case (r_state)
        ST_RUN: begin
          if (s_axis_tlast) begin
            // Frame end; a short frame also drops its partial word
            w_err       = ~w_is_last_subc;
            w_subc_nxt  = '0;
            w_bitc_nxt  = '0;
            w_wordc_nxt = '0;
            w_shift_nxt = '0;
          end else if (w_is_last_subc) begin
            w_err       = 1'b1;
            w_state_nxt = ST_RESYNC;
            w_subc_nxt  = '0;
            w_bitc_nxt  = '0;
            w_wordc_nxt = '0;
            w_shift_nxt = '0;
          end else begin
            w_subc_nxt = r_subc + SUBC_W'(1);
            if (w_is_data) begin
              w_shift_nxt[r_bitc] = w_bit;
              if (r_bitc == 5'd31) begin
                w_push      = 1'b1;
                w_push_word = w_shift_nxt;
                w_push_last = (r_wordc == WORD_W'(WORDS - 1));
                w_wordc_nxt = w_push_last ? '0 : r_wordc + WORD_W'(1);
                w_bitc_nxt  = '0;
              end else begin
                w_bitc_nxt = r_bitc + 5'd1;
              end
            end
          end
        end
        ST_RESYNC: begin
          if (s_axis_tlast) begin
            w_state_nxt = ST_RUN;
            w_subc_nxt  = '0;
            w_bitc_nxt  = '0;
            w_wordc_nxt = '0;
            w_shift_nxt = '0;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State, counters and error reporting
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= ST_RUN;
      r_subc      <= '0;
      r_bitc      <= '0;
      r_wordc     <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_subc      <= w_subc_nxt;
      r_bitc      <= w_bitc_nxt;
      r_wordc     <= w_wordc_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  // Output word FIFO; push and pop may coincide
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_push_last, w_push_word};
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_demapper.sv
// Scoreboard bench for bpsk_demapper: a frame-level reference model predicts output
// words and framing errors; a monitor checks every output handshake against it.
module tb_bpsk_demapper;

  localparam int FFT      = 1024;
  localparam int LO_LAST  = 400;
  localparam int HI_FIRST = 623;
  localparam int WORDS    = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mod;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        frame_err;
  logic [15:0] err_count;

  bpsk_demapper #(
    .FFT_SIZE (FFT),
    .LO_LAST  (LO_LAST),
    .HI_FIRST (HI_FIRST),
    .OUT_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reset_mod    (reset_mod),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  bit          mbits[$];
  int          m_pos, m_word;
  bit          m_resync;
  int          exp_err_cnt;
  int          exp_err_events = 0;

  int err_seen   = 0;
  int words_seen = 0;
  int lasts_seen = 0;

  bit m_fix   = 1'b0;
  bit bp_rand = 1'b0;
  bit gap_en  = 1'b0;
  bit lat_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_data(input int p);
    return (p >= 1 && p <= LO_LAST) || (p >= HI_FIRST && p <= FFT - 2);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mbits.delete();
    m_pos       = 0;
    m_word      = 0;
    m_resync    = 1'b0;
    exp_err_cnt = 0;
  endfunction

  function automatic void model_err();
    exp_err_events++;
    if (exp_err_cnt < 65535) exp_err_cnt++;
  endfunction

  // Reference: a frame is FFT samples ending in tlast; data bits collect 32 at a time
  function automatic void model_accept(input logic [15:0] re, input logic last);
    logic [31:0] w;
    if (m_resync) begin
      if (last) begin
        m_resync = 1'b0;
        m_pos    = 0;
      end
      return;
    end
    if (last) begin
      if (m_pos != FFT - 1) model_err();
      mbits.delete();
      m_pos  = 0;
      m_word = 0;
      return;
    end
    if (m_pos == FFT - 1) begin
      model_err();
      mbits.delete();
      m_resync = 1'b1;
      m_pos    = 0;
      m_word   = 0;
      return;
    end
    if (is_data(m_pos)) begin
      mbits.push_back(!re[15]);
      if (mbits.size() == 32) begin
        for (int i = 0; i < 32; i++) w[i] = mbits[i];
        exp_q.push_back({(m_word == WORDS - 1), w});
        m_word = (m_word + 1) % WORDS;
        mbits.delete();
      end
    end
    m_pos++;
  endfunction

  // Downstream ready driver
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_rand ? 1'($urandom_range(0, 1)) : m_fix;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (frame_err) err_seen++;
    if (rst && !reset_mod && m_tvalid && m_tready) begin
      words_seen++;
      if (m_tlast) lasts_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h last=%0b expected none", m_tdata, m_tlast);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 64'({m_tlast, m_tdata}), 64'(e));
      end
    end
  end

  task automatic send(input logic [15:0] re, input logic last, input logic [15:0] im);
    int waitc;
    if (gap_en && $urandom_range(0, 7) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_tdata  = {im, re};
    s_tlast  = last;
    s_tvalid = 1'b1;
    waitc    = 0;
    @(negedge clk);
    while (!s_tready) begin
      waitc++;
      if (waitc > 5000) begin
        $display("FAIL send_timeout: s_axis_tready stuck at 0 expected 1");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_accept(re, last);
  endtask

  // mode 0: alternating 0x7FFF/0x8000 on data subcarriers; mode 1: random samples
  task automatic send_frame(input int n, input int last_at, input int mode, input logic [15:0] null_val);
    int k;
    logic [15:0] re;
    logic [15:0] im;
    k = 0;
    for (int i = 0; i < n; i++) begin
      im = (mode == 1) ? 16'($urandom) : 16'h0000;
      if (is_data(i)) begin
        re = (mode == 1) ? 16'($urandom) : ((k % 2 == 0) ? 16'h7FFF : 16'h8000);
        k++;
      end else begin
        re = (mode == 1) ? 16'($urandom) : null_val;
      end
      send(re, (i == last_at), im);
      if (lat_chk && (i == 31 || i == 32)) begin
        @(negedge clk);
        check((i == 31) ? "latency_before" : "latency_after", 64'(m_tvalid), (i == 32) ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("idle_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("tready_in_reset", 64'(s_tready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_tready", 64'(s_tready), 64'd1);
    check("rst_outputs", 64'({m_tvalid, m_tlast, frame_err, m_tdata, err_count}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int w0, l0;
  bit fill_seen;

  initial begin
    rst       = 1'b0;
    reset_mod = 1'b0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Alternating frame, downstream always ready
    m_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    w0 = words_seen; l0 = lasts_seen;
    lat_chk = 1'b1;
    send_frame(FFT, FFT - 1, 0, 16'h0000);
    lat_chk = 1'b0;
    drain();
    check("frame_words", 64'(words_seen - w0), 64'(WORDS));
    check("frame_lasts", 64'(lasts_seen - l0), 64'd1);
    check("frame_no_err", 64'(err_seen), 64'd0);

    // Backpressure: FIFO fills to 4, then releases in order
    m_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    w0 = words_seen; l0 = lasts_seen;
    fill_seen = 1'b0;
    fork
      send_frame(FFT, FFT - 1, 0, 16'h0000);
      begin
        for (int c = 0; c < 3000 && !fill_seen; c++) begin
          @(negedge clk);
          if (!s_tready) fill_seen = 1'b1;
        end
        check("fill_tready_drop", 64'(fill_seen), 64'd1);
        check("fill_depth", 64'(exp_q.size()), 64'd4);
        check("fill_head", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b0, 32'h5555_5555});
        repeat (10) @(negedge clk);
        check("fill_hold_tready", 64'(s_tready), 64'd0);
        check("fill_no_pop", 64'(words_seen - w0), 64'd0);
        m_fix = 1'b1;
      end
    join
    drain();
    check("bp_words", 64'(words_seen - w0), 64'(WORDS));
    check("bp_lasts", 64'(lasts_seen - l0), 64'd1);

    // Non-zero nulls must not matter
    w0 = words_seen;
    send_frame(FFT, FFT - 1, 0, 16'h7FFF);
    drain();
    check("nulls_words", 64'(words_seen - w0), 64'(WORDS));

    // Short frame then a good one
    do_reset();
    w0 = words_seen; l0 = err_seen;
    send_frame(501, 500, 0, 16'h0000);
    send_frame(FFT, FFT - 1, 0, 16'h0000);
    drain();
    check("short_err_pulses", 64'(err_seen - l0), 64'd1);
    check("short_err_count", 64'(err_count), 64'd1);
    check("short_words", 64'(words_seen - w0), 64'(12 + WORDS));

    // Long frame (1030 samples) then a good one
    do_reset();
    w0 = words_seen; l0 = err_seen;
    send_frame(1030, 1029, 0, 16'h0000);
    send_frame(FFT, FFT - 1, 0, 16'h0000);
    drain();
    check("long_err_pulses", 64'(err_seen - l0), 64'd1);
    check("long_err_count", 64'(err_count), 64'd1);
    check("long_words", 64'(words_seen - w0), 64'(WORDS + WORDS));

    // Soft reset mid-frame with 2 words buffered
    m_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(70, -1, 0, 16'h0000);
    @(negedge clk);
    check("softrst_pre_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    reset_mod = 1'b1;
    @(negedge clk);
    check("softrst_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    reset_mod = 1'b0;
    model_reset();
    @(negedge clk);
    check("softrst_tvalid", 64'(m_tvalid), 64'd0);
    check("softrst_tready_after", 64'(s_tready), 64'd1);
    m_fix = 1'b1;
    @(posedge clk);
    #1;
    w0 = words_seen; l0 = lasts_seen;
    send_frame(FFT, FFT - 1, 0, 16'h0000);
    drain();
    check("softrst_words", 64'(words_seen - w0), 64'(WORDS));
    check("softrst_lasts", 64'(lasts_seen - l0), 64'd1);

    // Randomized frames with random backpressure, gaps, short and long frames
    bp_rand = 1'b1;
    gap_en  = 1'b1;
    l0 = err_seen;
    w0 = exp_err_events;
    send_frame(FFT, FFT - 1, 1, 16'h0000);
    send_frame(FFT, int'($urandom_range(1, FFT - 2)), 1, 16'h0000);
    send_frame(FFT, FFT - 1, 1, 16'h0000);
    send_frame(FFT + int'($urandom_range(1, 5)), -2, 1, 16'h0000);
    send(16'h1234, 1'b1, 16'h0000);
    send_frame(FFT, FFT - 1, 1, 16'h0000);
    drain();
    bp_rand = 1'b0;
    gap_en  = 1'b0;
    check("rand_err_pulses", 64'(err_seen - l0), 64'(exp_err_events - w0));
    check("rand_err_count", 64'(err_count), 64'(exp_err_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
